// File: rtl/adxl345_pkg.sv
// Shared definitions for the ADXL345 SPI responder: register map, reset values,
// FSM state encoding and the debug view.
package adxl345_pkg;

  localparam logic [7:0] DEVID_DEFAULT = 8'hE5;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [7:0] RST_BW_RATE     = 8'h0A;
  localparam logic [7:0] RST_POWER_CTL   = 8'h00;
  localparam logic [7:0] RST_INT_ENABLE  = 8'h00;
  localparam logic [7:0] RST_INT_MAP     = 8'h00;
  localparam logic [7:0] RST_DATA_FORMAT = 8'h00;

  typedef enum logic [2:0] {IDLE, CMD, RD, WR, IGNORE} state_e;

  typedef struct packed {
    state_e state;
    logic   cs_lvl;
    logic   sclk_lvl;
    logic   mosi_toggle;
  } dbg_t;

  function automatic logic is_data_addr(input logic [5:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

endpackage

// File: rtl/adxl345_spi_responder_if.sv
// Pin bundle of the ADXL345 responder: 4-wire SPI (mode 3), sample inputs, interrupts.
interface adxl345_spi_responder_if;
  // sample_valid is a one-cycle strobe with no ready: the responder always accepts it.
  // SPI pins have no handshake; the master owns sclk/cs/mosi, the responder owns miso/oe.
  logic        spi_sclk;
  logic        spi_cs;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [15:0] sample_x;
  logic [15:0] sample_y;
  logic [15:0] sample_z;
  logic        sample_valid;
  logic        int1;
  logic        int2;
  logic        busy;

  modport master (
    output spi_sclk, spi_cs, spi_mosi, sample_x, sample_y, sample_z, sample_valid,
    input  spi_miso, spi_miso_oe, int1, int2, busy
  );

  modport slave (
    input  spi_sclk, spi_cs, spi_mosi, sample_x, sample_y, sample_z, sample_valid,
    output spi_miso, spi_miso_oe, int1, int2, busy
  );
endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with rise/fall pulses; edges are suppressed until the
// chain has refilled after reset so a pin held active through reset is not seen as an edge.
module spi_edge_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   fill_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{INIT}};
      prev_q <= INIT;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = fill_q[STAGES] & level_o & ~prev_q;
  assign fall_o  = fill_q[STAGES] & ~level_o & prev_q;

endmodule

// File: rtl/adxl345_spi_responder.sv
// ADXL345 SPI (mode 3) register-file responder with DATA_READY capture.
// Optional feature macro: ADXL_RESP_INT_EN (writable INT_ENABLE/INT_MAP, int1/int2 outputs).
module adxl345_spi_responder
  import adxl345_pkg::*;
#(
  parameter logic [7:0] DEVID       = DEVID_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  adxl345_spi_responder_if.slave   bus,
  output dbg_t                     dbg_o
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_sclk (
    .clk_i(sys_clk), .rst_ni(reset_n), .din_i(bus.spi_sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
    .clk_i(sys_clk), .rst_ni(reset_n), .din_i(bus.spi_cs),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
    .clk_i(sys_clk), .rst_ni(reset_n), .din_i(bus.spi_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d;
  logic [5:0]  addr_q, addr_d;
  logic        mb_q, mb_d, miso_q, miso_d;
  logic        drdy_q, drdy_d, rd_data_q, rd_data_d;
  logic [7:0]  bw_rate_q, bw_rate_d, power_ctl_q, power_ctl_d, data_format_q, data_format_d;
  logic [47:0] shadow_q, shadow_d, snap_q, snap_d;
`ifdef ADXL_RESP_INT_EN
  logic [7:0]  int_enable_q, int_enable_d, int_map_q, int_map_d;
  logic        int1_q, int2_q;
`endif

  logic [7:0] rx_next, rd_byte;
  logic [5:0] load_addr;
  logic       capture, write_en;

  assign rx_next   = {rx_q[6:0], mosi_lvl};
  // The byte loaded at a boundary is either the command's address or the next burst address.
  assign load_addr = (state_q == CMD) ? rx_next[5:0] : addr_q + 6'd1;
  assign capture   = bus.sample_valid & power_ctl_q[3];

  always_comb begin : read_mux
    rd_byte = 8'h00;
    case (load_addr)
      ADDR_DEVID:         rd_byte = DEVID;
      ADDR_BW_RATE:       rd_byte = bw_rate_q;
      ADDR_POWER_CTL:     rd_byte = power_ctl_q;
`ifdef ADXL_RESP_INT_EN
      ADDR_INT_ENABLE:    rd_byte = int_enable_q;
      ADDR_INT_MAP:       rd_byte = int_map_q;
`endif
      ADDR_INT_SOURCE:    rd_byte = {drdy_q, 5'b00000, 2'b10};
      ADDR_DATA_FORMAT:   rd_byte = data_format_q;
      ADDR_DATAX0:        rd_byte = snap_q[7:0];
      ADDR_DATAX0 + 6'd1: rd_byte = snap_q[15:8];
      ADDR_DATAX0 + 6'd2: rd_byte = snap_q[23:16];
      ADDR_DATAX0 + 6'd3: rd_byte = snap_q[31:24];
      ADDR_DATAX0 + 6'd4: rd_byte = snap_q[39:32];
      ADDR_DATAZ1:        rd_byte = snap_q[47:40];
      default:            rd_byte = 8'h00;
    endcase
  end

  always_comb begin : next_state
    state_d = state_q;   bit_cnt_d = bit_cnt_q; rx_d = rx_q;   tx_d = tx_q;
    addr_d  = addr_q;    mb_d = mb_q;           miso_d = miso_q;
    drdy_d  = drdy_q;    rd_data_d = rd_data_q; shadow_d = shadow_q; snap_d = snap_q;
    bw_rate_d = bw_rate_q; power_ctl_d = power_ctl_q; data_format_d = data_format_q;
`ifdef ADXL_RESP_INT_EN
    int_enable_d = int_enable_q; int_map_d = int_map_q;
`endif
    write_en = 1'b0;

    if (capture) shadow_d = {bus.sample_z, bus.sample_y, bus.sample_x};

    if (cs_fall) begin
      state_d = CMD; bit_cnt_d = '0; miso_d = 1'b0; tx_d = '0; rd_data_d = 1'b0;
      snap_d  = shadow_d;
    end else if (cs_rise) begin
      state_d = IDLE; bit_cnt_d = '0; miso_d = 1'b0;
      if (rd_data_q) drdy_d = 1'b0;
    end else if (state_q != IDLE) begin
      if (sclk_fall) begin
        miso_d = (state_q == RD) ? tx_q[7] : 1'b0;
        if (state_q == RD) tx_d = {tx_q[6:0], 1'b0};
      end
      if (sclk_rise) begin
        rx_d      = rx_next;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              mb_d   = rx_next[6];
              addr_d = rx_next[5:0];
              if (rx_next[7]) begin
                state_d = RD;
                tx_d    = rd_byte;
              end else begin
                state_d = WR;
              end
            end
            RD: begin
              if (is_data_addr(addr_q)) rd_data_d = 1'b1;
              if (mb_q) begin
                addr_d = load_addr;
                tx_d   = rd_byte;
              end else begin
                state_d = IGNORE;
                tx_d    = '0;
              end
            end
            WR: begin
              write_en = 1'b1;
              if (mb_q) addr_d = load_addr;
              else      state_d = IGNORE;
            end
            default: ;
          endcase
        end
      end
    end

    if (write_en) begin
      case (addr_q)
        ADDR_BW_RATE:     bw_rate_d     = rx_next;
        ADDR_POWER_CTL:   power_ctl_d   = rx_next;
        ADDR_DATA_FORMAT: data_format_d = rx_next;
`ifdef ADXL_RESP_INT_EN
        ADDR_INT_ENABLE:  int_enable_d  = rx_next;
        ADDR_INT_MAP:     int_map_d     = rx_next;
`endif
        default: ;
      endcase
    end

    // A capture in the same cycle as the end-of-read clear must leave DATA_READY set.
    if (capture) drdy_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;   bit_cnt_q <= '0; rx_q <= '0; tx_q <= '0;
      addr_q  <= '0;     mb_q <= 1'b0;    miso_q <= 1'b0;
      drdy_q  <= 1'b0;   rd_data_q <= 1'b0;
      shadow_q <= '0;    snap_q <= '0;
      bw_rate_q <= RST_BW_RATE; power_ctl_q <= RST_POWER_CTL; data_format_q <= RST_DATA_FORMAT;
    end else begin
      state_q <= state_d; bit_cnt_q <= bit_cnt_d; rx_q <= rx_d; tx_q <= tx_d;
      addr_q  <= addr_d;  mb_q <= mb_d;           miso_q <= miso_d;
      drdy_q  <= drdy_d;  rd_data_q <= rd_data_d;
      shadow_q <= shadow_d; snap_q <= snap_d;
      bw_rate_q <= bw_rate_d; power_ctl_q <= power_ctl_d; data_format_q <= data_format_d;
    end
  end

`ifdef ADXL_RESP_INT_EN
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      int_enable_q <= RST_INT_ENABLE; int_map_q <= RST_INT_MAP;
      int1_q <= 1'b0; int2_q <= 1'b0;
    end else begin
      int_enable_q <= int_enable_d; int_map_q <= int_map_d;
      int1_q <= drdy_q & int_enable_q[7] & ~int_map_q[7];
      int2_q <= drdy_q & int_enable_q[7] &  int_map_q[7];
    end
  end
  assign bus.int1 = int1_q;
  assign bus.int2 = int2_q;
`else
  assign bus.int1 = 1'b0;
  assign bus.int2 = 1'b0;
`endif

  assign bus.busy        = ~cs_lvl & (state_q != IDLE);
  assign bus.spi_miso_oe = ~cs_lvl & (state_q != IDLE);
  assign bus.spi_miso    = miso_q;
  assign dbg_o           = {state_q, cs_lvl, sclk_lvl, mosi_rise | mosi_fall};

endmodule
